// File: rtl/receptor_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and default word width.
package receptor_pkg;

  localparam int unsigned LARGURA_PADRAO = 16;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DADOS    = 2'd1,
    PARIDADE = 2'd2,
    PARADA   = 2'd3
  } estado_t;

endpackage

// File: rtl/receptor_serial_16b_contador_bits.sv
// Data-bit counter for the serial receiver: enable-gated, synchronously clearable,
// saturates at LARGURA-1 and flags that terminal count.
module contador_bits
  import receptor_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_fim_c
);

  localparam int unsigned W = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  logic [W-1:0] r_cnt;

  // Holds at the terminal count so it can never wrap inside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_fim_c) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_fim_c = (r_cnt == W'(LARGURA - 1));

endmodule

// File: rtl/receptor_serial_16b.sv
// Serial-to-parallel frame receiver: start bit, LARGURA data bits LSB first, optional parity,
// stop bit. Parity support is compiled in with RECEPTOR_SERIAL_PARIDADE_EN.
module receptor_serial_16b
  import receptor_pkg::*;
#(
  parameter int unsigned LARGURA        = LARGURA_PADRAO,
  parameter int unsigned PARIDADE_IMPAR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_en,
  input  logic               rx,
  output logic [LARGURA-1:0] d,
  output logic               l,
  output logic               erro,
  output logic               ocupado
);

  if (PARIDADE_IMPAR > 1) begin : g_paridade_invalida
    $error("PARIDADE_IMPAR must be 0 or 1");
  end

  estado_t            r_estado, w_estado_prox;
  logic [LARGURA-1:0] r_desloc, w_desloc_prox;
  logic [LARGURA-1:0] r_d, w_d_prox;
  logic               r_l, w_l_prox;
  logic               r_erro, w_erro_prox;
  logic               r_ocupado, w_ocupado_prox;
  logic               w_cnt_clr;
  logic               w_cnt_en;
  logic               w_fim;
  logic               w_quadro_ok;

  contador_bits #(
    .LARGURA (LARGURA)
  ) u_contador_bits (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .o_fim_c (w_fim)
  );

`ifdef RECEPTOR_SERIAL_PARIDADE_EN
  logic r_par, w_par_prox;

  // Running XOR over data and parity bits must equal the configured sense
  assign w_quadro_ok = rx && (r_par == 1'(PARIDADE_IMPAR));
`else
  assign w_quadro_ok = rx;
`endif

  // Next-state, datapath and strobe decode; nothing moves without bit_en
  always_comb begin
    w_estado_prox = r_estado;
    w_desloc_prox = r_desloc;
    w_d_prox      = r_d;
    w_l_prox      = 1'b0;
    w_erro_prox   = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
    w_par_prox    = r_par;
`endif
    if (bit_en) begin
      case (r_estado)
        OCIOSO: begin
          if (!rx) begin
            w_estado_prox = DADOS;
            w_cnt_clr     = 1'b1;
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
            w_par_prox    = 1'b0;
`endif
          end
        end
        DADOS: begin
          w_desloc_prox = {rx, r_desloc[LARGURA-1:1]};
          w_cnt_en      = 1'b1;
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
          w_par_prox    = r_par ^ rx;
          if (w_fim) w_estado_prox = PARIDADE;
`else
          if (w_fim) w_estado_prox = PARADA;
`endif
        end
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
        PARIDADE: begin
          w_par_prox    = r_par ^ rx;
          w_estado_prox = PARADA;
        end
`endif
        PARADA: begin
          w_estado_prox = OCIOSO;
          if (w_quadro_ok) begin
            w_d_prox = r_desloc;
            w_l_prox = 1'b1;
          end else begin
            w_erro_prox = 1'b1;
          end
        end
        default: w_estado_prox = OCIOSO;
      endcase
    end
    w_ocupado_prox = (w_estado_prox != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_desloc  <= '0;
      r_d       <= '0;
      r_l       <= 1'b0;
      r_erro    <= 1'b0;
      r_ocupado <= 1'b0;
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_estado  <= w_estado_prox;
      r_desloc  <= w_desloc_prox;
      r_d       <= w_d_prox;
      r_l       <= w_l_prox;
      r_erro    <= w_erro_prox;
      r_ocupado <= w_ocupado_prox;
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
      r_par     <= w_par_prox;
`endif
    end
  end

  assign d       = r_d;
  assign l       = r_l;
  assign erro    = r_erro;
  assign ocupado = r_ocupado;

endmodule

// File: tb/tb_receptor_serial_16b.sv
// Self-checking bench for receptor_serial_16b: directed frames from the test plan followed by
// randomized frames, compared against a frame-level model of the receiver.
module tb_receptor_serial_16b;

  localparam int unsigned LARGURA        = 16;
  localparam int unsigned PARIDADE_IMPAR = 0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               bit_en;
  logic               rx;
  logic [LARGURA-1:0] d;
  logic               l;
  logic               erro;
  logic               ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LARGURA-1:0] exp_d;

  receptor_serial_16b #(
    .LARGURA        (LARGURA),
    .PARIDADE_IMPAR (PARIDADE_IMPAR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_en  (bit_en),
    .rx      (rx),
    .d       (d),
    .l       (l),
    .erro    (erro),
    .ocupado (ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_correta(input logic [LARGURA-1:0] w);
    return (^w) ^ 1'(PARIDADE_IMPAR);
  endfunction

  // One bit_en sample: rx set at the falling edge, outputs read just after the rising edge
  task automatic amostra(input logic b);
    @(negedge clk);
    rx     = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Remaining cycles of a tick period: rx toggled as noise, strobes must stay low
  task automatic espaco(input int periodo, input string tag);
    for (int i = 1; i < periodo; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
      rx     = 1'($urandom);
      @(posedge clk);
      #1;
      check({tag, " gap strobes"}, {30'd0, l, erro}, 32'd0);
    end
  endtask

  task automatic ocioso(input int n, input int periodo);
    for (int i = 0; i < n; i++) begin
      amostra(1'b1);
      check("idle", {29'd0, l, erro, ocupado}, 32'd0);
      espaco(periodo, "idle");
    end
  endtask

  task automatic quadro(input logic [LARGURA-1:0] w, input logic stop, input logic par,
                        input int periodo, input string tag);
    logic bom;
    amostra(1'b0);
    check({tag, " start"}, {29'd0, l, erro, ocupado}, 32'd1);
    espaco(periodo, tag);
    for (int i = 0; i < int'(LARGURA); i++) begin
      amostra(w[i]);
      check({tag, " data"}, {29'd0, l, erro, ocupado}, 32'd1);
      espaco(periodo, tag);
    end
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
    amostra(par);
    check({tag, " parity"}, {29'd0, l, erro, ocupado}, 32'd1);
    espaco(periodo, tag);
    bom = stop && (par == par_correta(w));
`else
    bom = stop;
    if (par) bom = stop;
`endif
    amostra(stop);
    if (bom) exp_d = w;
    check({tag, " stop strobes"}, {29'd0, l, erro, ocupado}, {29'd0, bom, !bom, 1'b0});
    check({tag, " d"}, 32'(d), 32'(exp_d));
    espaco(periodo, tag);
  endtask

  initial begin
    logic [LARGURA-1:0] w;
    logic               stop;
    logic               par;
    int                 periodo;

    rst_n  = 1'b0;
    bit_en = 1'b0;
    rx     = 1'b1;
    exp_d  = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {29'd0, l, erro, ocupado}, 32'd0);
    check("reset d", 32'(d), 32'd0);
    rst_n = 1'b1;

    ocioso(2, 1);
    quadro(16'hA5C3, 1'b0, par_correta(16'hA5C3), 1, "bad_stop");
    quadro(16'hA5C3, 1'b1, par_correta(16'hA5C3), 1, "a5c3");
    ocioso(1, 1);
    quadro(16'h0001, 1'b1, par_correta(16'h0001), 4, "slow_0001");
    quadro(16'h1234, 1'b1, par_correta(16'h1234), 1, "b2b_1234");
    quadro(16'hFFFF, 1'b1, par_correta(16'hFFFF), 1, "b2b_ffff");
`ifdef RECEPTOR_SERIAL_PARIDADE_EN
    quadro(16'hA5C3, 1'b1, 1'b0, 1, "par0_a5c3");
    quadro(16'h0F0F, 1'b1, 1'b0, 1, "par0_0f0f");
    quadro(16'hA5C3, 1'b1, 1'b1, 1, "par1_a5c3");
`endif

    // Abort 16'hBEEF after its 7th data bit
    w = 16'hBEEF;
    amostra(1'b0);
    for (int i = 0; i < 7; i++) amostra(w[i]);
    check("mid-frame busy", {31'd0, ocupado}, 32'd1);
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    exp_d = '0;
    check("abort outputs", {29'd0, l, erro, ocupado}, 32'd0);
    check("abort d", 32'(d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ocioso(1, 2);
    quadro(16'h00F0, 1'b1, par_correta(16'h00F0), 1, "after_abort");

    for (int k = 0; k < 40; k++) begin
      w       = LARGURA'($urandom);
      stop    = ($urandom_range(0, 3) != 0);
      par     = par_correta(w) ^ ($urandom_range(0, 3) == 0);
      periodo = $urandom_range(1, 4);
      ocioso($urandom_range(0, 2), periodo);
      quadro(w, stop, par, periodo, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
